// File: rtl/four_12_12_err_sched.sv
// Error-stage sequencer for four_12_12: buffers the expected stream in a ring of external
// memory and pairs each network sample with the oldest buffered expected value on zctrl.
module four_12_12_err_sched #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   expected,
   input  logic          expected_vld,
   input  logic          expected_fst,
   output logic          expected_rdy,
   input  logic [31:0]   stage_3_data_out,
   input  logic          stage_3_data_out_vld,
   input  logic          stage_3_data_out_fst,
   output logic          stage_3_data_out_rdy,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_wr_addr,
   output logic [31:0]   mem_wr_data,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [31:0]   mem_rd_data,
   output logic [31:0]   zctrl_out,
   output logic [31:0]   zctrl_exp,
   output logic          zctrl_vld,
   output logic          zctrl_fst,
   input  logic          zctrl_rdy,
   output logic [AW:0]   count,
   output logic          frame_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t          state_r;
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [AW:0]     count_r;
   logic [DEPTH-1:0] fst_flags_r;
   logic [31:0]     sample_r;
   logic            sample_fst_r;
   logic            stored_fst_r;
   logic [31:0]     zctrl_out_r;
   logic [31:0]     zctrl_exp_r;
   logic            zctrl_vld_r;
   logic            zctrl_fst_r;
   logic            frame_err_r;

   logic            wr_fire_s;
   logic            rd_fire_s;
   logic            expected_rdy_s;

   // Write side: accept while not full; the write goes straight through to the memory port
   always_comb begin
      expected_rdy_s = 1'b0;
      if (reset && (count_r != FULL_CNT)) begin
         expected_rdy_s = 1'b1;
      end else begin
         expected_rdy_s = 1'b0;
      end
      wr_fire_s = expected_rdy_s && expected_vld;
   end

   // Read issue: a sample is taken only when an entry is stored and the pair slot is free
   always_comb begin
      rd_fire_s = 1'b0;
      if (reset && stage_3_data_out_vld && (count_r != '0)) begin
         case (state_r)
            IDLE:    rd_fire_s = 1'b1;
            HOLD:    rd_fire_s = zctrl_rdy;
            default: rd_fire_s = 1'b0;
         endcase
      end else begin
         rd_fire_s = 1'b0;
      end
   end

   // Ring pointers, occupancy and per-entry frame-start flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         fst_flags_r <= '0;
      end else begin
         if (wr_fire_s) begin
            wr_ptr_r              <= wr_ptr_r + 1'b1;
            fst_flags_r[wr_ptr_r] <= expected_fst;
         end
         if (rd_fire_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({wr_fire_s, rd_fire_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Pairing FSM: latch sample on issue, merge with read data one cycle later, hold until taken
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= IDLE;
         sample_r     <= 32'h0000_0000;
         sample_fst_r <= 1'b0;
         stored_fst_r <= 1'b0;
         zctrl_out_r  <= 32'h0000_0000;
         zctrl_exp_r  <= 32'h0000_0000;
         zctrl_vld_r  <= 1'b0;
         zctrl_fst_r  <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         if (rd_fire_s) begin
            sample_r     <= stage_3_data_out;
            sample_fst_r <= stage_3_data_out_fst;
            stored_fst_r <= fst_flags_r[rd_ptr_r];
         end
         case (state_r)
            IDLE: begin
               if (rd_fire_s) begin
                  state_r <= READ;
               end else begin
                  state_r <= IDLE;
               end
            end
            READ: begin
               zctrl_exp_r <= mem_rd_data;
               zctrl_out_r <= sample_r;
               zctrl_fst_r <= sample_fst_r;
               zctrl_vld_r <= 1'b1;
               state_r     <= HOLD;
               // Frame misalignment is only flagged; the pair still goes downstream
               if (sample_fst_r != stored_fst_r) begin
                  frame_err_r <= 1'b1;
               end
            end
            HOLD: begin
               if (zctrl_rdy) begin
                  zctrl_vld_r <= 1'b0;
                  if (rd_fire_s) begin
                     state_r <= READ;
                  end else begin
                     state_r <= IDLE;
                  end
               end
            end
            default: begin
               state_r     <= IDLE;
               zctrl_vld_r <= 1'b0;
            end
         endcase
      end
   end

   assign expected_rdy         = expected_rdy_s;
   assign stage_3_data_out_rdy = rd_fire_s;
   assign mem_wr_en            = wr_fire_s;
   assign mem_wr_addr          = wr_ptr_r;
   assign mem_wr_data          = expected;
   assign mem_rd_en            = rd_fire_s;
   assign mem_rd_addr          = rd_ptr_r;
   assign zctrl_out            = zctrl_out_r;
   assign zctrl_exp            = zctrl_exp_r;
   assign zctrl_vld            = zctrl_vld_r;
   assign zctrl_fst            = zctrl_fst_r;
   assign count                = count_r;
   assign frame_err            = frame_err_r;

endmodule

// File: tb/tb_four_12_12_err_sched.sv
// Self-checking bench for four_12_12_err_sched: a reference model with a pair scoreboard
// checked every cycle, plus a vector table and hand sequences for the corner cases.
module tb_four_12_12_err_sched;

   logic        clk;
   logic        reset;
   logic [31:0] expected;
   logic        expected_vld;
   logic        expected_fst;
   logic        expected_rdy;
   logic [31:0] stage_3_data_out;
   logic        stage_3_data_out_vld;
   logic        stage_3_data_out_fst;
   logic        stage_3_data_out_rdy;
   logic        mem_wr_en;
   logic [3:0]  mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic        mem_rd_en;
   logic [3:0]  mem_rd_addr;
   logic [31:0] mem_rd_data;
   logic [31:0] zctrl_out;
   logic [31:0] zctrl_exp;
   logic        zctrl_vld;
   logic        zctrl_fst;
   logic        zctrl_rdy;
   logic [4:0]  count;
   logic        frame_err;

   four_12_12_err_sched #(.DEPTH(16), .AW(4)) dut (
      .clk                  (clk),
      .reset                (reset),
      .expected             (expected),
      .expected_vld         (expected_vld),
      .expected_fst         (expected_fst),
      .expected_rdy         (expected_rdy),
      .stage_3_data_out     (stage_3_data_out),
      .stage_3_data_out_vld (stage_3_data_out_vld),
      .stage_3_data_out_fst (stage_3_data_out_fst),
      .stage_3_data_out_rdy (stage_3_data_out_rdy),
      .mem_wr_en            (mem_wr_en),
      .mem_wr_addr          (mem_wr_addr),
      .mem_wr_data          (mem_wr_data),
      .mem_rd_en            (mem_rd_en),
      .mem_rd_addr          (mem_rd_addr),
      .mem_rd_data          (mem_rd_data),
      .zctrl_out            (zctrl_out),
      .zctrl_exp            (zctrl_exp),
      .zctrl_vld            (zctrl_vld),
      .zctrl_fst            (zctrl_fst),
      .zctrl_rdy            (zctrl_rdy),
      .count                (count),
      .frame_err            (frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected-value memory: synchronous write, read data valid the cycle after the strobe
   logic [31:0] mem [16];
   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
   endtask

   typedef struct {
      logic [31:0] v;
      logic        f;
   } ent_t;

   typedef struct {
      logic [31:0] out;
      logic [31:0] ex;
      logic        fst;
   } pair_t;

   ent_t  mq[$];
   pair_t sb[$];
   int    m_cnt = 0;
   logic [3:0] m_wp = 4'd0;
   logic [3:0] m_rp = 4'd0;
   int    m_ph = 0;
   logic  m_ferr = 1'b0;
   logic  m_mis = 1'b0;
   logic  m_in_rst = 1'b0;
   int    hs_q[$];

   // Reference model: checks outputs mid-cycle, then advances to the state after the next edge
   always @(negedge clk) begin
      logic  e_rdy, e_acc, s_rdy;
      ent_t  ent;
      pair_t pr;
      if (!reset) begin
         check("rst_expected_rdy", 32'(expected_rdy), 32'd0);
         check("rst_s3_rdy", 32'(stage_3_data_out_rdy), 32'd0);
         check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
         check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
         if (m_in_rst) begin
            check("rst_count", 32'(count), 32'd0);
            check("rst_zctrl_vld", 32'(zctrl_vld), 32'd0);
            check("rst_zctrl_fst", 32'(zctrl_fst), 32'd0);
            check("rst_zctrl_out", zctrl_out, 32'd0);
            check("rst_zctrl_exp", zctrl_exp, 32'd0);
            check("rst_frame_err", 32'(frame_err), 32'd0);
         end
         m_in_rst = 1'b1;
         m_cnt = 0; m_wp = 4'd0; m_rp = 4'd0; m_ph = 0; m_ferr = 1'b0; m_mis = 1'b0;
         mq.delete(); sb.delete();
      end else begin
         m_in_rst = 1'b0;
         e_rdy = (m_cnt != 16);
         e_acc = e_rdy && expected_vld;
         s_rdy = stage_3_data_out_vld && (m_cnt != 0) && ((m_ph == 0) || (m_ph == 2 && zctrl_rdy));
         check("expected_rdy", 32'(expected_rdy), 32'(e_rdy));
         check("s3_rdy", 32'(stage_3_data_out_rdy), 32'(s_rdy));
         check("mem_wr_en", 32'(mem_wr_en), 32'(e_acc));
         if (e_acc) begin
            check("mem_wr_addr", 32'(mem_wr_addr), 32'(m_wp));
            check("mem_wr_data", mem_wr_data, expected);
         end
         check("mem_rd_en", 32'(mem_rd_en), 32'(s_rdy));
         if (s_rdy) check("mem_rd_addr", 32'(mem_rd_addr), 32'(m_rp));
         check("count", 32'(count), 32'(m_cnt));
         check("zctrl_vld", 32'(zctrl_vld), 32'(m_ph == 2));
         check("frame_err", 32'(frame_err), 32'(m_ferr));
         if (m_ph == 2) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               check("sb_zctrl_out", zctrl_out, sb[0].out);
               check("sb_zctrl_exp", zctrl_exp, sb[0].ex);
               check("sb_zctrl_fst", 32'(zctrl_fst), 32'(sb[0].fst));
            end
         end
         case (m_ph)
            1: begin m_ferr = m_ferr | m_mis; m_ph = 2; end
            2: if (zctrl_rdy) begin
                  if (sb.size() != 0) void'(sb.pop_front());
                  m_ph = s_rdy ? 1 : 0;
               end
            default: if (s_rdy) m_ph = 1;
         endcase
         if (s_rdy && mq.size() != 0) begin
            ent    = mq.pop_front();
            pr.out = stage_3_data_out;
            pr.ex  = ent.v;
            pr.fst = stage_3_data_out_fst;
            sb.push_back(pr);
            m_mis = (ent.f != stage_3_data_out_fst);
            m_rp  = m_rp + 4'd1;
         end
         if (e_acc) begin
            ent.v = expected;
            ent.f = expected_fst;
            mq.push_back(ent);
            m_wp = m_wp + 4'd1;
         end
         if (e_acc && !s_rdy) m_cnt = m_cnt + 1;
         if (s_rdy && !e_acc) m_cnt = m_cnt - 1;
      end
   end

   // Handshake log for throughput measurement
   always @(negedge clk) begin
      if (reset && zctrl_vld && zctrl_rdy) hs_q.push_back(cyc);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_exp(input logic [31:0] v, input logic f);
      bit done = 1'b0;
      expected = v; expected_fst = f; expected_vld = 1'b1;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         done = expected_rdy;
         tick();
      end
      expected_vld = 1'b0;
      if (!done) check("put_exp_timeout", 32'd0, 32'd1);
   endtask

   task automatic put_smp(input logic [31:0] v, input logic f);
      bit done = 1'b0;
      stage_3_data_out = v; stage_3_data_out_fst = f; stage_3_data_out_vld = 1'b1;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         done = stage_3_data_out_rdy;
         tick();
      end
      stage_3_data_out_vld = 1'b0;
      if (!done) check("put_smp_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_pair(output logic [31:0] o, output logic [31:0] e, output logic f, output logic fe);
      bit got = 1'b0;
      o = 32'd0; e = 32'd0; f = 1'b0; fe = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         if (zctrl_vld) begin
            got = 1'b1; o = zctrl_out; e = zctrl_exp; f = zctrl_fst; fe = frame_err;
         end
         tick();
      end
      if (!got) check("wait_pair_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [31:0] ev;
      logic        ef;
      logic [31:0] sv;
      logic        sf;
      logic [31:0] w_exp;
      logic        w_fst;
      logic        w_ferr;
   } vec_t;

   vec_t tbl[3];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] o, e;
      logic        f, fe;
      int          idx;
      tbl[0] = '{32'h3F80_0000, 1'b1, 32'hC000_0001, 1'b1, 32'h3F80_0000, 1'b1, 1'b0};
      tbl[1] = '{32'h4000_0000, 1'b0, 32'hC000_0002, 1'b0, 32'h4000_0000, 1'b0, 1'b0};
      tbl[2] = '{32'h4040_0000, 1'b0, 32'hC000_0003, 1'b0, 32'h4040_0000, 1'b0, 1'b0};

      // Reset with both valids high
      reset = 1'b0; zctrl_rdy = 1'b1;
      expected = 32'h1234_5678; expected_fst = 1'b1; expected_vld = 1'b1;
      stage_3_data_out = 32'h8765_4321; stage_3_data_out_fst = 1'b1; stage_3_data_out_vld = 1'b1;
      tick(); tick();
      @(negedge clk);
      check("reset_count", 32'(count), 32'd0);
      check("reset_zctrl_vld", 32'(zctrl_vld), 32'd0);
      check("reset_exp_rdy", 32'(expected_rdy), 32'd0);
      check("reset_s3_rdy", 32'(stage_3_data_out_rdy), 32'd0);
      tick();
      expected_vld = 1'b0; stage_3_data_out_vld = 1'b0; reset = 1'b1;

      // Basic pairing from the vector table
      for (int i = 0; i < 3; i++) put_exp(tbl[i].ev, tbl[i].ef);
      for (int i = 0; i < 3; i++) begin
         put_smp(tbl[i].sv, tbl[i].sf);
         wait_pair(o, e, f, fe);
         check("tbl_zctrl_exp", e, tbl[i].w_exp);
         check("tbl_zctrl_out", o, tbl[i].sv);
         check("tbl_zctrl_fst", 32'(f), 32'(tbl[i].w_fst));
         check("tbl_frame_err", 32'(fe), 32'(tbl[i].w_ferr));
      end
      tick(); tick();
      @(negedge clk);
      check("basic_count_zero", 32'(count), 32'd0);
      tick();

      // Full and wrap from a clean start
      reset = 1'b0; tick(); tick(); reset = 1'b1;
      for (int i = 0; i < 16; i++) put_exp(32'h1000_0000 + 32'(i), (i == 0));
      @(negedge clk);
      check("full_count", 32'(count), 32'd16);
      check("full_exp_rdy", 32'(expected_rdy), 32'd0);
      tick();
      expected = 32'hAAAA_0017; expected_fst = 1'b0; expected_vld = 1'b1;
      tick(); tick();
      stage_3_data_out = 32'h5000_0000; stage_3_data_out_fst = 1'b1; stage_3_data_out_vld = 1'b1;
      @(negedge clk);
      check("full_read_rdy", 32'(stage_3_data_out_rdy), 32'd1);
      check("full_read_addr", 32'(mem_rd_addr), 32'd0);
      tick();
      stage_3_data_out_vld = 1'b0;
      @(negedge clk);
      check("wrap_wr_en", 32'(mem_wr_en), 32'd1);
      check("wrap_wr_addr", 32'(mem_wr_addr), 32'd0);
      check("wrap_rd_addr", 32'(mem_rd_addr), 32'd1);
      tick();
      expected_vld = 1'b0;
      for (int i = 0; i < 16; i++) put_smp(32'h5000_0001 + 32'(i), 1'b0);
      repeat (4) tick();
      @(negedge clk);
      check("wrap_drained", 32'(count), 32'd0);
      tick();

      // Empty with a same-cycle write: no bypass
      expected = 32'h4080_0000; expected_fst = 1'b1; expected_vld = 1'b1;
      stage_3_data_out = 32'h6000_0000; stage_3_data_out_fst = 1'b1; stage_3_data_out_vld = 1'b1;
      @(negedge clk);
      check("empty_s3_rdy", 32'(stage_3_data_out_rdy), 32'd0);
      tick();
      expected_vld = 1'b0;
      @(negedge clk);
      check("empty_next_rdy", 32'(stage_3_data_out_rdy), 32'd1);
      check("empty_next_rd_en", 32'(mem_rd_en), 32'd1);
      tick();
      stage_3_data_out_vld = 1'b0;
      wait_pair(o, e, f, fe);
      check("empty_pair_exp", e, 32'h4080_0000);

      // Simultaneous write and read keeps occupancy
      put_exp(32'h40A0_0000, 1'b0);
      repeat (3) tick();
      expected = 32'h40C0_0000; expected_fst = 1'b0; expected_vld = 1'b1;
      stage_3_data_out = 32'h6000_0001; stage_3_data_out_fst = 1'b0; stage_3_data_out_vld = 1'b1;
      @(negedge clk);
      check("simul_pre_count", 32'(count), 32'd1);
      check("simul_both_rdy", 32'({expected_rdy, stage_3_data_out_rdy}), 32'd3);
      tick();
      expected_vld = 1'b0; stage_3_data_out_vld = 1'b0;
      @(negedge clk);
      check("simul_count", 32'(count), 32'd1);
      tick();
      wait_pair(o, e, f, fe);
      check("simul_pair_exp", e, 32'h40A0_0000);
      put_smp(32'h6000_0002, 1'b0);
      wait_pair(o, e, f, fe);
      check("simul_pair2_exp", e, 32'h40C0_0000);

      // Backpressure for 5 cycles, then back-to-back release
      for (int i = 0; i < 4; i++) put_exp(32'h4100_0000 + 32'(i), 1'b0);
      zctrl_rdy = 1'b0;
      stage_3_data_out = 32'h7000_0000; stage_3_data_out_fst = 1'b0; stage_3_data_out_vld = 1'b1;
      tick();
      stage_3_data_out = 32'h7000_0001;
      tick();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_vld", 32'(zctrl_vld), 32'd1);
         check("bp_out", zctrl_out, 32'h7000_0000);
         check("bp_exp", zctrl_exp, 32'h4100_0000);
         check("bp_no_accept", 32'(stage_3_data_out_rdy), 32'd0);
         tick();
      end
      hs_q.delete();
      zctrl_rdy = 1'b1;
      idx = 1;
      for (int n = 0; n < 40 && idx < 4; n++) begin
         logic acc;
         @(negedge clk);
         acc = stage_3_data_out_rdy;
         tick();
         if (acc) begin
            idx++;
            stage_3_data_out = 32'h7000_0000 + 32'(idx);
         end
      end
      stage_3_data_out_vld = 1'b0;
      repeat (4) tick();
      check("bp_pairs", 32'(hs_q.size()), 32'd4);
      for (int i = 1; i < hs_q.size(); i++) check("bp_interval", 32'(hs_q[i] - hs_q[i-1]), 32'd2);

      // Frame error: stored fst=0, sample fst=1
      put_exp(32'h4200_0000, 1'b0);
      put_smp(32'h8000_0000, 1'b1);
      wait_pair(o, e, f, fe);
      check("ferr_set", 32'(fe), 32'd1);
      check("ferr_data_exp", e, 32'h4200_0000);
      check("ferr_data_out", o, 32'h8000_0000);
      put_exp(32'h4200_0001, 1'b0);
      put_smp(32'h8000_0001, 1'b0);
      wait_pair(o, e, f, fe);
      check("ferr_sticky", 32'(fe), 32'd1);
      check("ferr_flow_exp", e, 32'h4200_0001);

      // Reset mid-operation discards buffer and pending pair
      put_exp(32'h4300_0000, 1'b0);
      put_exp(32'h4300_0001, 1'b0);
      put_smp(32'h9000_0000, 1'b0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      @(negedge clk);
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_vld", 32'(zctrl_vld), 32'd0);
      check("midrst_ferr", 32'(frame_err), 32'd0);
      check("midrst_exp_rdy", 32'(expected_rdy), 32'd1);
      tick();
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
